// File: rtl/mdl_abspgcntr_pkg.sv
// Shared constants, op encoding and request helpers for the bit-serial absolute page counter.
package mdl_abspgcntr_pkg;

  localparam int CNTR_W     = 12;
  localparam int PAGE_MAX   = 2052;
  localparam int ROT_W      = 20;
  localparam int SLOT_LSB   = 0;
  localparam int SLOT_LATCH = 12;
  localparam int SLOT_CLR   = 19;

  typedef enum logic [1:0] {OP_IDLE, OP_INC, OP_CLR, OP_LD} op_t;

  // Encoding order is not priority order: CLR beats LD beats INC.
  function automatic logic [1:0] op_prio(input op_t op);
    case (op)
      OP_CLR:  return 2'd3;
      OP_LD:   return 2'd2;
      OP_INC:  return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic op_t req_decode(input logic clr, input logic ld, input logic adv);
    if (clr)      return OP_CLR;
    else if (ld)  return OP_LD;
    else if (adv) return OP_INC;
    else          return OP_IDLE;
  endfunction

endpackage

// File: rtl/mdl_abspgcntr_fa.sv
// One-bit full adder; used with b tied low as the serial incrementer cell.
module mdl_abspgcntr_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/mdl_abspgcntr.sv
// Bit-serial absolute page counter: recirculating 12-bit register streamed LSB-first in slots 0..11,
// with one increment/clear/load op per 20-slot frame.
module mdl_abspgcntr
  import mdl_abspgcntr_pkg::*;
(
  input  logic              i_MCLK,
  input  logic              i_RST_n,
  input  logic              i_CLK2M_PCEN_n,
  input  logic [ROT_W-1:0]  i_ROT20_n,
  input  logic              i_PGADV,
  input  logic              i_ABSPG_CLR,
  input  logic              i_ABSPG_LD,
  input  logic              i_LD_BIT,
  output logic              o_ABSPGCNTR_LSB,
  output logic [CNTR_W-1:0] o_ABSPG,
  output logic              o_ABSPG_WRAP,
  output logic              o_BUSY
);

  localparam logic [CNTR_W-1:0] PAGE_MAX_BITS = CNTR_W'(PAGE_MAX);

  logic              en;
  logic              shift_slot;
  logic              latch_slot;
  logic              clr_slot;
  logic              pm_bit;
  logic              bit_out;
  logic              in_bit;
  logic              sum_bit;
  logic              carry_out;
  logic [CNTR_W-1:0] sr;
  op_t               pend_op;
  op_t               act_op;
  op_t               req_op;
  logic              carry;
  logic              neq;
  logic              eq;
  logic              wrap;

  // A rotator with no slot asserted is treated as "no slot": nothing advances.
  assign en         = ~i_CLK2M_PCEN_n & ~(&i_ROT20_n);
  assign shift_slot = |(~i_ROT20_n[SLOT_LSB +: CNTR_W]);
  assign latch_slot = ~i_ROT20_n[SLOT_LATCH];
  assign clr_slot   = ~i_ROT20_n[SLOT_CLR];
  assign pm_bit     = |(~i_ROT20_n[SLOT_LSB +: CNTR_W] & PAGE_MAX_BITS);
  assign bit_out    = sr[0];
  assign req_op     = req_decode(i_ABSPG_CLR, i_ABSPG_LD, i_PGADV);

  mdl_abspgcntr_fa u_fa (
    .a  (bit_out),
    .b  (1'b0),
    .ci (carry),
    .s  (sum_bit),
    .co (carry_out)
  );

  always_comb begin
    in_bit = bit_out;
    case (act_op)
      OP_INC:  in_bit = eq ? 1'b0 : sum_bit;
      OP_CLR:  in_bit = 1'b0;
      OP_LD:   in_bit = i_LD_BIT;
      default: in_bit = bit_out;
    endcase
  end

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      sr      <= '0;
      pend_op <= OP_IDLE;
      act_op  <= OP_IDLE;
      carry   <= 1'b0;
      neq     <= 1'b0;
      eq      <= 1'b0;
      wrap    <= 1'b0;
      o_ABSPG <= '0;
    end else if (en) begin
      wrap <= 1'b0;
      if (shift_slot) begin
        sr  <= {in_bit, sr[CNTR_W-1:1]};
        neq <= neq | (bit_out ^ pm_bit);
        if (act_op == OP_INC) carry <= carry_out;
      end
      if (latch_slot) begin
        o_ABSPG <= sr;
        eq      <= ~neq;
        wrap    <= (act_op == OP_INC) && eq;
      end
      // A request in the hand-over cycle stays pending for the frame after next.
      if (clr_slot) begin
        act_op  <= pend_op;
        pend_op <= req_op;
        neq     <= 1'b0;
        carry   <= (pend_op == OP_INC);
      end else if (op_prio(req_op) > op_prio(pend_op)) begin
        pend_op <= req_op;
      end
    end
  end

  assign o_ABSPGCNTR_LSB = sr[0];
  assign o_ABSPG_WRAP    = wrap;
  assign o_BUSY          = (pend_op != OP_IDLE) || (act_op != OP_IDLE);

endmodule

// File: tb/tb_mdl_abspgcntr.sv
// Directed bench for mdl_abspgcntr: frame-level stimulus with hand-computed expected values.
module tb_mdl_abspgcntr;

  logic        clk;
  logic        rst_n;
  logic        pcen_n;
  logic [19:0] rot;
  logic        pgadv;
  logic        clr;
  logic        ld;
  logic        ld_bit;
  logic        lsb;
  logic [11:0] abspg;
  logic        wrap;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int slot   = 0;
  logic [11:0] lw;
  int          nw;

  mdl_abspgcntr dut (
    .i_MCLK          (clk),
    .i_RST_n         (rst_n),
    .i_CLK2M_PCEN_n  (pcen_n),
    .i_ROT20_n       (rot),
    .i_PGADV         (pgadv),
    .i_ABSPG_CLR     (clr),
    .i_ABSPG_LD      (ld),
    .i_LD_BIT        (ld_bit),
    .o_ABSPGCNTR_LSB (lsb),
    .o_ABSPG         (abspg),
    .o_ABSPG_WRAP    (wrap),
    .o_BUSY          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    slot = (slot == 19) ? 0 : slot + 1;
    rot  = ~(20'd1 << slot);
  endtask

  // One full frame from slot 0; request pulses at the given slots (-1 = none).
  task automatic frame(input int adv_a, input int adv_b, input int clr_at, input int ld_at,
                       input logic [11:0] ld_data, output logic [11:0] lsb_word, output int wraps);
    lsb_word = '0;
    wraps    = 0;
    for (int s = 0; s < 20; s++) begin
      pgadv  = (s == adv_a) || (s == adv_b);
      clr    = (s == clr_at);
      ld     = (s == ld_at);
      ld_bit = (s < 12) ? ld_data[s] : 1'b0;
      if (s < 12) lsb_word[s] = lsb;
      tick();
      if (wrap) wraps++;
    end
    pgadv  = 1'b0;
    clr    = 1'b0;
    ld     = 1'b0;
    ld_bit = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    pcen_n = 1'b0;
    rot    = ~20'd1;
    pgadv  = 1'b0;
    clr    = 1'b0;
    ld     = 1'b0;
    ld_bit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_abspg", abspg, 0);
    chk("rst_lsb", lsb, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    repeat (3) frame(-1, -1, -1, -1, 12'd0, lw, nw);
    chk("idle_abspg", abspg, 0);
    chk("idle_lsb", lw, 0);
    chk("idle_busy", busy, 0);

    frame(2, -1, -1, -1, 12'd0, lw, nw);
    chk("adv_busy", busy, 1);
    frame(2, -1, -1, -1, 12'd0, lw, nw);
    chk("inc1_lsb_preop", lw, 0);
    chk("inc1_abspg", abspg, 1);
    frame(2, -1, -1, -1, 12'd0, lw, nw);
    chk("inc2_abspg", abspg, 2);
    frame(-1, -1, -1, -1, 12'd0, lw, nw);
    chk("inc3_abspg", abspg, 3);
    chk("inc3_lsb", lw, 2);
    chk("inc3_nowrap", nw, 0);
    frame(-1, -1, -1, -1, 12'd0, lw, nw);
    chk("val3_lsb", lw, 3);
    chk("val3_busy", busy, 0);

    frame(-1, -1, -1, 3, 12'd0, lw, nw);
    frame(-1, -1, -1, -1, 12'h804, lw, nw);
    chk("ld2052_abspg", abspg, 2052);
    chk("ld2052_lsb_preop", lw, 3);
    frame(2, -1, -1, -1, 12'd0, lw, nw);
    chk("pre_wrap_abspg", abspg, 2052);
    frame(-1, -1, -1, -1, 12'd0, lw, nw);
    chk("wrap_abspg", abspg, 0);
    chk("wrap_count", nw, 1);
    chk("wrap_lsb", lw, 2052);

    frame(-1, -1, -1, 3, 12'd0, lw, nw);
    frame(5, -1, -1, -1, 12'd2051, lw, nw);
    chk("ld2051_abspg", abspg, 2051);
    frame(-1, -1, -1, -1, 12'd0, lw, nw);
    chk("inc2051_abspg", abspg, 2052);
    chk("inc2051_nowrap", nw, 0);

    frame(-1, -1, -1, 3, 12'd0, lw, nw);
    frame(-1, -1, -1, -1, 12'd100, lw, nw);
    chk("ld100_abspg", abspg, 100);
    frame(4, -1, 4, -1, 12'd0, lw, nw);
    chk("advclr_busy", busy, 1);
    frame(-1, -1, -1, -1, 12'd0, lw, nw);
    chk("clr_abspg", abspg, 0);
    chk("clr_lsb_preop", lw, 100);
    frame(-1, -1, -1, -1, 12'd0, lw, nw);
    chk("clr_noinc_abspg", abspg, 0);
    chk("clr_noinc_busy", busy, 0);

    frame(2, 9, -1, -1, 12'd0, lw, nw);
    frame(-1, -1, -1, -1, 12'd0, lw, nw);
    frame(-1, -1, -1, -1, 12'd0, lw, nw);
    chk("coalesce_abspg", abspg, 1);
    chk("coalesce_busy", busy, 0);

    frame(2, -1, -1, -1, 12'd0, lw, nw);
    frame(19, -1, -1, -1, 12'd0, lw, nw);
    chk("slot19_first_abspg", abspg, 2);
    frame(-1, -1, -1, -1, 12'd0, lw, nw);
    chk("slot19_gap_abspg", abspg, 2);
    chk("slot19_gap_busy", busy, 1);
    frame(-1, -1, -1, -1, 12'd0, lw, nw);
    chk("slot19_total_abspg", abspg, 3);

    pcen_n = 1'b1;
    pgadv  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    pgadv  = 1'b0;
    pcen_n = 1'b0;
    chk("freeze_busy", busy, 0);
    chk("freeze_abspg", abspg, 3);
    frame(-1, -1, -1, -1, 12'd0, lw, nw);
    chk("freeze_lsb", lw, 3);
    chk("freeze_after_busy", busy, 0);

    frame(-1, -1, -1, 3, 12'd0, lw, nw);
    frame(-1, -1, -1, -1, 12'd5, lw, nw);
    frame(2, -1, -1, -1, 12'd0, lw, nw);
    chk("pre_rst_abspg", abspg, 5);
    for (int s = 0; s < 6; s++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_abspg", abspg, 0);
    chk("midrst_lsb", lsb, 0);
    chk("midrst_wrap", wrap, 0);
    chk("midrst_busy", busy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20 && slot != 0; k++) tick();
    frame(-1, -1, -1, -1, 12'd0, lw, nw);
    frame(-1, -1, -1, -1, 12'd0, lw, nw);
    chk("postrst_abspg", abspg, 0);
    chk("postrst_lsb", lw, 0);
    chk("postrst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
